// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional even parity, SB_TICK-tick stop.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_tx_start,
    input  logic [DBIT-1:0] i_data,
    input  logic            i_s_tick,
    output logic            o_tx,
    output logic            o_tx_done_tick,
    output logic            o_busy
);

    localparam int SMAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] DATA_LAST = NW'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    state_t state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_tx_start) begin
                    state_d = START;
                    s_d     = '0;
                    n_d     = '0;
                    b_d     = i_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^i_data;
`endif
                end
            end
            START: begin
                if (i_s_tick) begin
                    if (s_q == BIT_LAST) begin
                        state_d = DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (i_s_tick) begin
                    if (s_q == BIT_LAST) begin
                        state_d = STOP;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (i_s_tick) begin
                    if (s_q == STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The line level is derived from the next state, so the registered o_tx
    // always matches the state the frame is in after the same clock edge.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign o_tx           = tx_q;
    assign o_tx_done_tick = done_q;
    assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-clock comparison against a tick-count frame model.
// Build with UART_TX_PARITY_EN defined to exercise the parity variant.
module tb_uart_tx;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int NSLOT = 1 + DBIT + NPAR;
    localparam int FRAME = 16 * NSLOT + SB_TICK;

    logic            i_clk;
    logic            i_reset;
    logic            i_tx_start;
    logic [DBIT-1:0] i_data;
    logic            i_s_tick;
    logic            o_tx;
    logic            o_tx_done_tick;
    logic            o_busy;

    int checks = 0;
    int errors = 0;

    uart_tx #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_tx_start     (i_tx_start),
        .i_data         (i_data),
        .i_s_tick       (i_s_tick),
        .o_tx           (o_tx),
        .o_tx_done_tick (o_tx_done_tick),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected line level once k ticks of a frame have elapsed: each slot is 16 ticks.
    function automatic logic model_line(input logic [DBIT-1:0] data, input int k);
        int slot;
        if (k >= FRAME) return 1'b1;
        slot = k / 16;
        if (slot == 0) return 1'b0;
        if (slot <= DBIT) return data[slot-1];
        if (NPAR == 1 && slot == DBIT + 1) return ^data;
        return 1'b1;
    endfunction

    task automatic clk_step(input logic tick);
        i_s_tick = tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_frame(input logic [DBIT-1:0] data, input bit hold);
        i_tx_start = 1'b1;
        i_data     = data;
        clk_step(1'($urandom_range(0, 1)));
        if (!hold) i_tx_start = 1'b0;
        checks++;
        if (o_tx !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_line: got %b required 0", o_tx);
        end
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_busy: got %b required 1", o_busy);
        end
    endtask

    // Drives a frame that has already been accepted to completion (or abort).
    task automatic play_frame(input logic [DBIT-1:0] data, input int period,
                              input bit scramble, input int inject_cyc, input int abort_k);
        int k   = 0;
        int cyc = 0;
        logic tick;
        logic exp_tx;
        while (k < FRAME) begin
            if (inject_cyc >= 0 && cyc == inject_cyc) begin
                i_tx_start = 1'b1;
                i_data     = '0;
            end else if (inject_cyc >= 0 && cyc == inject_cyc + 1) begin
                i_tx_start = 1'b0;
            end else if (scramble) begin
                i_data = DBIT'($urandom);
            end
            tick = ((cyc % period) == (period - 1));
            clk_step(tick);
            cyc++;
            if (tick) k++;
            exp_tx = model_line(data, k);
            checks++;
            if (o_tx !== exp_tx) begin
                errors++;
                $display("[TB] FAIL frame_line: data=%h tick=%0d got %b required %b", data, k, o_tx, exp_tx);
            end
            checks++;
            if (o_busy !== (k < FRAME)) begin
                errors++;
                $display("[TB] FAIL frame_busy: data=%h tick=%0d got %b required %b", data, k, o_busy, k < FRAME);
            end
            checks++;
            if (o_tx_done_tick !== (tick && k == FRAME)) begin
                errors++;
                $display("[TB] FAIL frame_done: data=%h tick=%0d got %b required %b",
                         data, k, o_tx_done_tick, tick && k == FRAME);
            end
            if (abort_k >= 0 && k == abort_k) begin
                #2;
                i_reset = 1'b1;
                #1;
                checks++;
                if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_done_tick !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL abort_immediate: got tx=%b busy=%b done=%b required tx=1 busy=0 done=0",
                             o_tx, o_busy, o_tx_done_tick);
                end
                return;
            end
        end
    endtask

    task automatic idle_clocks(input int n);
        for (int i = 0; i < n; i++) begin
            clk_step(1'($urandom_range(0, 1)));
            checks++;
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_done_tick !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_state: got tx=%b busy=%b done=%b required tx=1 busy=0 done=0",
                         o_tx, o_busy, o_tx_done_tick);
            end
        end
    endtask

    // Steps a frame with a tick every 4 clocks against a literal bit sequence.
    task automatic check_vector(input logic [DBIT-1:0] data, input logic seq [NSLOT+1]);
        logic exp_tx;
        start_frame(data, 1'b0);
        for (int j = 1; j <= FRAME * 4; j++) begin
            clk_step(j % 4 == 0);
            exp_tx = (j / 64 < NSLOT + 1) ? seq[j/64] : 1'b1;
            checks++;
            if (o_tx !== exp_tx) begin
                errors++;
                $display("[TB] FAIL vector_line: data=%h clock=%0d got %b required %b", data, j, o_tx, exp_tx);
            end
            checks++;
            if (o_busy !== (j < FRAME * 4)) begin
                errors++;
                $display("[TB] FAIL vector_busy: data=%h clock=%0d got %b required %b", data, j, o_busy, j < FRAME * 4);
            end
            checks++;
            if (o_tx_done_tick !== (j == FRAME * 4)) begin
                errors++;
                $display("[TB] FAIL vector_done: data=%h clock=%0d got %b required %b",
                         data, j, o_tx_done_tick, j == FRAME * 4);
            end
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        i_tx_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clk_step(1'b1);
            checks++;
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_done_tick !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_state: got tx=%b busy=%b done=%b required tx=1 busy=0 done=0",
                         o_tx, o_busy, o_tx_done_tick);
            end
        end
        i_tx_start = 1'b0;
        i_reset = 1'b0;
        idle_clocks(10);
    endtask

    task automatic test_known_vector;
        logic seq [NSLOT+1];
`ifdef UART_TX_PARITY_EN
        seq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        seq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
        check_vector(8'h96, seq);
        idle_clocks(5);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic seq [NSLOT+1];
        seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        check_vector(8'h25, seq);
        idle_clocks(5);
    endtask
`endif

    task automatic test_ignore_start;
        start_frame(8'hA5, 1'b0);
        play_frame(8'hA5, 4, 1'b0, 4 * 16 * 4 + 10, -1);
        idle_clocks(40);
        start_frame(8'h3C, 1'b0);
        play_frame(8'h3C, 4, 1'b1, FRAME * 4 - 1, -1);
        i_tx_start = 1'b0;
        idle_clocks(40);
    endtask

    task automatic test_reset_abort;
        start_frame(8'hC3, 1'b0);
        play_frame(8'hC3, 4, 1'b0, -1, 16 * 4 + 6);
        for (int i = 0; i < 2; i++) begin
            clk_step(1'b1);
            checks++;
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_done_tick !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_held: got tx=%b busy=%b done=%b required tx=1 busy=0 done=0",
                         o_tx, o_busy, o_tx_done_tick);
            end
        end
        i_reset = 1'b0;
        idle_clocks(20);
        start_frame(8'h5A, 1'b0);
        play_frame(8'h5A, 3, 1'b1, -1, -1);
        idle_clocks(5);
    endtask

    task automatic test_no_tick;
        start_frame(8'h81, 1'b0);
        for (int i = 0; i < 300; i++) begin
            clk_step(1'b0);
            checks++;
            if (o_tx !== 1'b0 || o_busy !== 1'b1 || o_tx_done_tick !== 1'b0) begin
                errors++;
                $display("[TB] FAIL no_tick_hold: got tx=%b busy=%b done=%b required tx=0 busy=1 done=0",
                         o_tx, o_busy, o_tx_done_tick);
            end
        end
        play_frame(8'h81, 2, 1'b0, -1, -1);
        idle_clocks(5);
    endtask

    task automatic test_back_to_back;
        start_frame(8'h21, 1'b1);
        i_data = 8'h22;
        play_frame(8'h21, 4, 1'b0, -1, -1);
        clk_step(1'b0);
        i_tx_start = 1'b0;
        checks++;
        if (o_tx !== 1'b0 || o_busy !== 1'b1 || o_tx_done_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_restart: got tx=%b busy=%b done=%b required tx=0 busy=1 done=0",
                     o_tx, o_busy, o_tx_done_tick);
        end
        play_frame(8'h22, 4, 1'b0, -1, -1);
        idle_clocks(10);
    endtask

    task automatic test_random;
        logic [DBIT-1:0] data;
        int period;
        for (int f = 0; f < 6; f++) begin
            data   = DBIT'($urandom);
            period = $urandom_range(1, 5);
            start_frame(data, 1'b0);
            play_frame(data, period, 1'b1, -1, -1);
            idle_clocks($urandom_range(1, 10));
        end
    endtask

    initial begin
        i_reset    = 1'b1;
        i_tx_start = 1'b0;
        i_data     = '0;
        i_s_tick   = 1'b0;
        #1;
        test_reset;
        test_known_vector;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        test_ignore_start;
        test_reset_abort;
        test_no_tick;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
